// File: rtl/axil_master_pkg.sv
// Shared definitions for the AXI4-Lite initiator: bus widths, FSM states, AXI response codes.
package axil_master_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } axil_state_e;

endpackage

// File: rtl/axil_master.sv
// Single-outstanding request/response port to AXI4-Lite initiator.
// Define AXIL_BRESP_EN to add the B channel and report bresp[1] as rsp_err.
module axil_master
  import axil_master_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
`ifdef AXIL_BRESP_EN
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
`endif
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  axil_state_e       state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              bready_q, bready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              aw_hs, w_hs;

  assign aw_hs = awvalid_q & m_axi_awready;
  assign w_hs  = wvalid_q & m_axi_wready;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (req_we) begin
            wdata_d   = req_wdata;
            wstrb_d   = req_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // AW and W complete independently; finish once both have been seen
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef AXIL_BRESP_EN
          state_d   = ST_WR_RESP;
`else
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
`endif
        end
      end
`ifdef AXIL_BRESP_EN
      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_axi_bresp == AXI_RESP_SLVERR) || (m_axi_bresp == AXI_RESP_DECERR);
          state_d     = ST_IDLE;
        end
      end
`endif
      ST_RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          rsp_rdata_d = m_axi_rdata;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    rready_d    = (state_d == ST_RD_DATA);
    bready_d    = (state_d == ST_WR_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
`ifdef AXIL_BRESP_EN
  assign m_axi_bready  = bready_q;
`else
  logic unused_bready;
  assign unused_bready = bready_q;
`endif

endmodule

// File: tb/tb_axil_master.sv
// Scoreboard bench for axil_master: randomized requests against a delay-programmable AXI-Lite slave.
module tb_axil_master;
  import axil_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
`ifdef AXIL_BRESP_EN
  logic [1:0]  bresp;
  logic        bvalid, bready;
`endif

  always #5 clk = ~clk;

  axil_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
`ifdef AXIL_BRESP_EN
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
`endif
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    bit          rd;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          acc_log[$];
  int          cyc = 0;
  logic [31:0] last_rd = '0;

  // Reference memory, updated at request acceptance
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  // Per-request slave wait cycles (nxt_* from stimulus, act_* latched on acceptance)
  int nxt_aw, nxt_w, nxt_ar, nxt_r, nxt_b;
  int act_aw, act_w, act_ar, act_r, act_b;

  function automatic bit slave_err(input logic [31:0] a);
    return a[6];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Acceptance: build the expected response from the request and the reference memory
  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      exp_t e;
      logic [31:0] old;
      e.acc = cyc;
      act_aw = nxt_aw; act_w = nxt_w; act_ar = nxt_ar; act_r = nxt_r; act_b = nxt_b;
      if (req_we) begin
        old = ref_mem.exists(req_addr) ? ref_mem[req_addr] : 32'h0;
        ref_mem[req_addr] = merge(old, req_wdata, req_wstrb);
        e.rd = 1'b0;
        e.rdata = '0;
`ifdef AXIL_BRESP_EN
        e.lat = 3 + ((nxt_aw > nxt_w) ? nxt_aw : nxt_w) + nxt_b;
        e.err = slave_err(req_addr);
`else
        e.lat = 2 + ((nxt_aw > nxt_w) ? nxt_aw : nxt_w);
        e.err = 1'b0;
`endif
      end else begin
        e.rd = 1'b1;
        e.rdata = ref_mem.exists(req_addr) ? ref_mem[req_addr] : 32'h0;
        e.lat = 3 + nxt_ar + nxt_r;
        e.err = 1'b0;
      end
      sb_q.push_back(e);
      acc_log.push_back(cyc);
    end
    cyc++;
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL spurious_rsp: got rsp_valid=1, expected 0 (nothing outstanding)");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        if (e.rd) last_rd = e.rdata;
        check(e.rd ? "rsp_rdata" : "rsp_rdata_hold", 64'(rsp_rdata), 64'(last_rd));
      end
    end
  end

  // Slave: handshake capture and protocol checks on the edge
  bit aw_got, w_got, r_pend, b_pend;
  logic [31:0] aw_a, w_d, r_addr, b_addr;
  logic [3:0]  w_s;
  int aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt;
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_got = 0; w_got = 0; r_pend = 0; b_pend = 0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    end else begin
      if (p_awv && !p_awr) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_wv && !p_wr)   check("w_hold", {wvalid, wstrb, wdata}, {1'b1, p_wstrb, p_wdata});
      if (p_arv && !p_arr) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      if (rready) check("rready_only_rd_data", 64'(r_pend), 64'd1);
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
      if (awvalid && awready) begin aw_got = 1; aw_a = awaddr; end
      if (wvalid && wready) begin w_got = 1; w_d = wdata; w_s = wstrb; end
      if (aw_got && w_got) begin
        slv_mem[aw_a] = merge(slv_mem.exists(aw_a) ? slv_mem[aw_a] : 32'h0, w_d, w_s);
        aw_got = 0; w_got = 0;
        b_pend = 1; b_cnt = 0; b_addr = aw_a;
      end
      if (rvalid && rready) r_pend = 0;
      if (arvalid && arready) begin r_pend = 1; r_cnt = 0; r_addr = araddr; end
`ifdef AXIL_BRESP_EN
      if (bready) check("bready_only_wr_resp", 64'(b_pend), 64'd1);
      if (bvalid && bready) b_pend = 0;
`else
      b_pend = 0;
`endif
    end
  end

  // Slave: ready/valid drive away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
`ifdef AXIL_BRESP_EN
      bvalid = 0; bresp = AXI_RESP_OKAY;
`endif
    end else begin
      if (awvalid) begin awready = (aw_cnt == act_aw); aw_cnt++; end else begin awready = 0; aw_cnt = 0; end
      if (wvalid)  begin wready  = (w_cnt == act_w);   w_cnt++;  end else begin wready  = 0; w_cnt  = 0; end
      if (arvalid) begin arready = (ar_cnt == act_ar); ar_cnt++; end else begin arready = 0; ar_cnt = 0; end
      if (r_pend) begin
        rvalid = (r_cnt >= act_r);
        rdata  = slv_mem.exists(r_addr) ? slv_mem[r_addr] : 32'h0;
        r_cnt++;
      end else rvalid = 0;
`ifdef AXIL_BRESP_EN
      if (b_pend) begin
        bvalid = (b_cnt >= act_b);
        bresp  = slave_err(b_addr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        b_cnt++;
      end else bvalid = 0;
`endif
    end
  end

  // Present one request starting at a negedge; returns at the negedge after acceptance
  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int daw, input int dw, input int dar, input int dr, input int db, input bit hold);
    int t;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    nxt_aw = daw; nxt_w = dw; nxt_ar = dar; nxt_r = dr; nxt_b = db;
    t = 0;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL req_accept_timeout: got req_ready=0 for %0d cycles, expected 1", t);
      req_valid = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: got %0d outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int t, wr_lat;
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    nxt_aw = 0; nxt_w = 0; nxt_ar = 0; nxt_r = 0; nxt_b = 0;
    act_aw = 0; act_w = 0; act_ar = 0; act_r = 0; act_b = 0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_valids", {awvalid, wvalid, arvalid, rready, rsp_valid, rsp_err}, 64'd0);
    check("reset_regs", {rsp_rdata, awaddr}, 64'd0);
    check("reset_wregs", {wdata, wstrb}, 64'd0);
    rst_n = 1;
    @(negedge clk);

    // Zero-wait write then registered-data read of the same word
    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0);
    wait_idle();
    do_req(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    wait_idle();
    // AW ready three cycles before W ready
    do_req(1, 32'h14, 32'h12345678, 4'h5, 0, 3, 0, 0, 0, 0);
    wait_idle();
    do_req(0, 32'h14, 32'h0, 4'h0, 0, 0, 2, 4, 0, 0);
    wait_idle();
    // Error-address write then OKAY write
    do_req(1, 32'h40, 32'hA5A5A5A5, 4'hF, 1, 0, 0, 0, 2, 0);
    wait_idle();
    do_req(1, 32'h18, 32'h0BADF00D, 4'hF, 0, 1, 0, 0, 0, 0);
    wait_idle();

    // Back-to-back write then read with req_valid held
    acc_log.delete();
    do_req(1, 32'h1C, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, 1);
    do_req(0, 32'h1C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    wait_idle();
`ifdef AXIL_BRESP_EN
    wr_lat = 3;
`else
    wr_lat = 2;
`endif
    if (acc_log.size() == 2) check("b2b_accept_gap", 64'(acc_log[1] - acc_log[0]), 64'(wr_lat));
    else check("b2b_accept_count", 64'(acc_log.size()), 64'd2);

    // Reset while waiting for read data
    do_req(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 20, 0, 0);
    t = 0;
    while (!rready && t < 50) begin @(negedge clk); t++; end
    check("reach_rd_data", 64'(rready), 64'd1);
    rst_n = 0;
    sb_q.delete();
    last_rd = '0;
    @(negedge clk);
    check("midrst_valids", {awvalid, wvalid, arvalid, rready, rsp_valid}, 64'd0);
    check("midrst_rdata", 64'(rsp_rdata), 64'd0);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);
    repeat (25) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      bit we, hold;
      logic [31:0] a;
      we   = 1'($urandom_range(0, 1));
      hold = (i != 149) && ($urandom_range(0, 2) == 0);
      a    = 32'($urandom_range(0, 31)) << 2;
      do_req(we, a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
